// File: rtl/decoder_2_to_4.sv
// 2-to-4 one-hot select decoder with a configurable output stage.
//   sel = {a,b}; y<sel> is active when en=1, and all outputs are inactive otherwise.
//   OUT_REG=1 registers the decode with one cycle of latency. OUT_REG=0 makes the
//   decode combinational.
//   ACTIVE_LOW=1 inverts every output, so the selected output reads 0 and the
//   others read 1.
//   rst is asynchronous and active-high. It forces all outputs inactive in both
//   output-stage configurations.
module decoder_2_to_4 #(
  parameter bit OUT_REG    = 1'b1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic y0,
  output logic y1,
  output logic y2,
  output logic y3
);

  // This mask turns the internal active-high vector into the configured output
  // polarity. With it, "inactive" is always the all-zero internal state.
  localparam logic [3:0] POL_MASK = {4{ACTIVE_LOW}};

  logic [1:0] sel;
  logic [3:0] dec;  // Raw active-high decode. Bit i is set when en && sel == i.
  logic [3:0] act;  // Active-high value after the output stage, gated by reset.

  assign sel = {a, b};

  // Decode the select into a one-hot vector, or into all-zero when en is low.
  always_comb begin
    // NOTE: every bit gets a default before the conditional write, so each path
    // fully assigns dec and no latch is inferred.
    dec = '0;
    if (en) begin
      dec[sel] = 1'b1;
    end
  end

  generate
    if (OUT_REG) begin : g_reg
      // Capture the decode on each rising edge. Reset clears it asynchronously.
      always_ff @(posedge clk or posedge rst) begin
        // NOTE: state updates use non-blocking assignments. All flops then sample
        // pre-edge values and no ordering race exists between processes.
        if (rst) begin
          act <= '0;
        end else begin
          act <= dec;
        end
      end
    end else begin : g_comb
      // Pass the decode straight through. rst still gates it to inactive.
      always_comb begin
        act = rst ? 4'b0000 : dec;
      end
    end
  endgenerate

  // Apply output polarity. This is a pure inversion, so registered outputs still
  // change only on clock edges or on reset.
  assign {y3, y2, y1, y0} = act ^ POL_MASK;

endmodule

// File: tb/tb_decoder_2_to_4.sv
// Directed and random bench for decoder_2_to_4.
//   dut_reg : default configuration (registered outputs, active-high).
//   dut_comb: combinational outputs, active-low.
// The bench builds all vectors in {y0,y1,y2,y3} order.
module tb_decoder_2_to_4;

  logic clk = 1'b0;
  logic rst, en, a, b;
  logic rst_c, en_c, a_c, b_c;
  logic r_y0, r_y1, r_y2, r_y3;
  logic c_y0, c_y1, c_y2, c_y3;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  decoder_2_to_4 dut_reg (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .a   (a),
    .b   (b),
    .y0  (r_y0),
    .y1  (r_y1),
    .y2  (r_y2),
    .y3  (r_y3)
  );

  decoder_2_to_4 #(
    .OUT_REG    (1'b0),
    .ACTIVE_LOW (1'b1)
  ) dut_comb (
    .clk (clk),
    .rst (rst_c),
    .en  (en_c),
    .a   (a_c),
    .b   (b_c),
    .y0  (c_y0),
    .y1  (c_y1),
    .y2  (c_y2),
    .y3  (c_y3)
  );

  function automatic logic [3:0] reg_out();
    return {r_y0, r_y1, r_y2, r_y3};
  endfunction

  function automatic logic [3:0] comb_out();
    return {c_y0, c_y1, c_y2, c_y3};
  endfunction

  // Reference decode in {y0,y1,y2,y3} order, active-high.
  function automatic logic [3:0] ref_dec(input logic e, input logic sa, input logic sb);
    logic [3:0] r;
    r = 4'b0000;
    if (e) begin
      case ({sa, sb})
        2'b00:   r = 4'b1000;
        2'b01:   r = 4'b0100;
        2'b10:   r = 4'b0010;
        default: r = 4'b0001;
      endcase
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b, expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive the registered DUT's inputs just after a falling edge.
  task automatic drive(input logic e, input logic sa, input logic sb);
    @(negedge clk);
    en = e;
    a  = sa;
    b  = sb;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] sweep_hi [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [3:0] sweep_lo [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  initial begin
    logic [3:0] prev;
    logic [3:0] exp;
    logic [1:0] s;
    logic e, sa, sb;

    rst = 1'b0; en = 1'b0; a = 1'b0; b = 1'b0;
    rst_c = 1'b0; en_c = 1'b0; a_c = 1'b0; b_c = 1'b0;

    // 1. Reset asserts ahead of the first clock edge and must clear the outputs
    //    asynchronously.
    #1 rst = 1'b1;
    #1 check("reset_async", reg_out(), 4'b0000);
    after_edge();
    after_edge();
    check("reset_held", reg_out(), 4'b0000);
    @(negedge clk) rst = 1'b0;

    // 2. Enabled sweep. Each result appears on the edge after the input changes,
    //    and the previous value is held until that edge.
    prev = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      s = 2'(i);
      drive(1'b1, s[1], s[0]);
      #1 check($sformatf("sweep%0d_hold", i), reg_out(), prev);
      after_edge();
      check($sformatf("sweep%0d", i), reg_out(), sweep_hi[i]);
      prev = sweep_hi[i];
    end

    // 3. With en low, the edge captures all-inactive. Raising en resumes decoding.
    drive(1'b0, 1'b1, 1'b0);
    after_edge();
    check("en_low", reg_out(), 4'b0000);
    drive(1'b1, 1'b1, 1'b0);
    after_edge();
    check("en_raise", reg_out(), 4'b0010);

    // 4. Reset asserted between edges clears the outputs at once. Decoding
    //    resumes on the first edge after release.
    drive(1'b1, 1'b1, 1'b1);
    after_edge();
    check("hold11", reg_out(), 4'b0001);
    #2 rst = 1'b1;
    #1 check("rst_mid", reg_out(), 4'b0000);
    after_edge();
    check("rst_mid_held", reg_out(), 4'b0000);
    @(negedge clk) rst = 1'b0;
    #1 check("rst_release_wait", reg_out(), 4'b0000);
    after_edge();
    check("rst_release", reg_out(), 4'b0001);
    // Reset raised exactly on a clock edge still wins.
    @(posedge clk) rst = 1'b1;
    #1 check("rst_on_edge", reg_out(), 4'b0000);
    @(negedge clk) rst = 1'b0;
    after_edge();
    check("rst_on_edge_release", reg_out(), 4'b0001);

    // 5. Combinational, active-low instance. No latency, and no clock is needed.
    en_c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s = 2'(i);
      a_c = s[1];
      b_c = s[0];
      #1 check($sformatf("comb%0d", i), comb_out(), sweep_lo[i]);
      #9;
    end
    rst_c = 1'b1;
    #1 check("comb_rst", comb_out(), 4'b1111);
    rst_c = 1'b0;
    #1 check("comb_rst_release", comb_out(), 4'b1110);
    en_c = 1'b0;
    #1 check("comb_en_low", comb_out(), 4'b1111);

    // 6. Random traffic on both instances. Each is compared against the reference
    //    decode, and the registered outputs must also stay one-hot or all-inactive.
    for (int i = 0; i < 200; i++) begin
      e  = ($urandom_range(3) != 0);
      sa = 1'($urandom_range(1));
      sb = 1'($urandom_range(1));
      drive(e, sa, sb);
      en_c = e; a_c = sa; b_c = sb;
      exp = ref_dec(e, sa, sb);
      #1 check($sformatf("rnd%0d_comb", i), comb_out(), ~exp);
      after_edge();
      check($sformatf("rnd%0d_reg", i), reg_out(), exp);
      check($sformatf("rnd%0d_onehot", i), {3'b000, ($countones(reg_out()) <= 1)}, 4'b0001);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
